gpr_file: RTL and testbench
===========================

# gpr_file

Architectural general-purpose register file for the multi-cycle PowerPC core: 32 registers of 64 bits, two synchronous read ports and two write ports. The core's decode state launches reads; execute and write-back consume the held read data. The core's write-back state commits results through port 0 (ALU/load result) and port 1 (update-form base register, e.g. `ldu`).

## Interface
Parameters:
- `NREGS`, 32: number of registers; address width is 5 bits.
- `DW`, 64: register width. Bit 0 is the MSB (big-endian `[0:DW-1]` numbering).

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `raddr0_en`  in  1  read port 0 enable.
- `raddr0`  in  5  read port 0 address.
- `rdata0`  out  64  read port 0 data, registered.
- `raddr1_en`  in  1  read port 1 enable.
- `raddr1`  in  5  read port 1 address.
- `rdata1`  out  64  read port 1 data, registered.
- `wen0`  in  1  write port 0 enable.
- `waddr0`  in  5  write port 0 address.
- `wdata0`  in  64  write port 0 data.
- `wen1`  in  1  write port 1 enable.
- `waddr1`  in  5  write port 1 address.
- `wdata1`  in  64  write port 1 data.

## Operation
- Storage is 32 × 64-bit registers. r0 is an ordinary storage register with no hard-wired zero; the core applies the "ra=0 means literal 0" rule outside this block.
- Reads:
  - When `raddrN_en` is high at a rising edge, `rdataN` loads `reg[raddrN]`.
  - When the enable is low, `rdataN` holds its previous value indefinitely. The core relies on this to use operands across several states.
- Writes:
  - When `wenN` is high at a rising edge, `reg[waddrN]` loads `wdataN`.
  - If both ports write the same address in the same cycle, port 1 wins.
  - Different addresses both commit.
- Both read ports may target the same address. Each returns the same value.
- Reset (synchronous, highest priority) clears all 32 registers and both `rdata0`/`rdata1` to 0. Any reads or writes in the reset cycle are ignored.
- Addresses are always in range (5-bit), so there is no out-of-range case.

## Timing
- Read latency: 1 cycle. Address and enable sampled at edge k; `rdataN` is valid after edge k and stable until the next enabled read or reset.
- Write latency: 1 cycle. Data written at edge k is readable by a read enabled at edge k+1 or later.
- Read and write to the same address in the same edge: behaviour depends on `GPR_BYPASS_EN` (see Configuration).
- Output values after reset: `rdata0` = `rdata1` = 0.
- No handshake; the block accepts an operation on every port on every cycle.

## Configuration
- `GPR_BYPASS_EN` defined:
  - A read enabled in the same cycle as a write to the same address returns the new write data.
  - Port 1 data takes priority if both write ports hit that address.
- `GPR_BYPASS_EN` undefined: such a read returns the old (pre-write) register contents; the write still commits.
- The multi-cycle core never overlaps reads and writes, so both builds are functionally correct for it. The macro exists for pipelined reuse.

## Test plan
- Reset clears everything: write 0xDEADBEEF_00000001 to r5, pulse `reset`, read r5 on both ports → `rdata0` = `rdata1` = 0.
- Basic read and hold:
  - Write r3 = 0x0000_0000_0000_0041 via port 0, then read r3 on port 1 → `rdata1` = 0x41 one cycle later.
  - Deassert `raddr1_en` and write r3 = 7 → `rdata1` stays 0x41.
- Dual write to different addresses: same edge, port 0 writes r4 = 0x10, port 1 writes r9 = 0x20 → subsequent reads give r4 = 0x10, r9 = 0x20.
- Write collision: same edge, port 0 writes r7 = 0x1111, port 1 writes r7 = 0x2222 → read r7 = 0x2222.
- Same-cycle read/write: r2 holds 5; write r2 = 9 and read r2 on the same edge → `rdata0` = 9 with `GPR_BYPASS_EN`, 5 without. A read on the next edge gives 9 in both builds.
- r0 is ordinary storage: write r0 = 0xFFFF_FFFF_FFFF_FFFF → read r0 returns all ones, not zero.

Source files
------------

// File: rtl/gpr_file.sv
// gpr_file: 32 x 64-bit architectural register file, two registered read ports, two write ports.
// Optional same-cycle write-to-read bypass is enabled by defining GPR_BYPASS_EN.
module gpr_file #(
    parameter  int unsigned NREGS = 32,
    parameter  int unsigned DW    = 64,
    localparam int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          raddr0_en,
    input  logic [AW-1:0] raddr0,
    output logic [0:DW-1] rdata0,
    input  logic          raddr1_en,
    input  logic [AW-1:0] raddr1,
    output logic [0:DW-1] rdata1,
    input  logic          wen0,
    input  logic [AW-1:0] waddr0,
    input  logic [0:DW-1] wdata0,
    input  logic          wen1,
    input  logic [AW-1:0] waddr1,
    input  logic [0:DW-1] wdata1
);

    logic [0:DW-1] regs_q [NREGS];
    logic [0:DW-1] regs_d [NREGS];
    logic [0:DW-1] rdata0_q, rdata0_d;
    logic [0:DW-1] rdata1_q, rdata1_d;

    // Next register contents; port 1 is applied last so it wins an address collision.
    always_comb begin
        regs_d = regs_q;
        if (wen0) begin
            regs_d[waddr0] = wdata0;
        end
        if (wen1) begin
            regs_d[waddr1] = wdata1;
        end
    end

    // Read data holds until the next enabled read.
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef GPR_BYPASS_EN
        if (raddr0_en) begin
            rdata0_d = regs_d[raddr0];
        end
        if (raddr1_en) begin
            rdata1_d = regs_d[raddr1];
        end
`else
        if (raddr0_en) begin
            rdata0_d = regs_q[raddr0];
        end
        if (raddr1_en) begin
            rdata1_d = regs_q[raddr1];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            regs_q   <= regs_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed cases plus randomized traffic against an array model.
module tb_gpr_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        raddr0_en, raddr1_en, wen0, wen1;
    logic [4:0]  raddr0, raddr1, waddr0, waddr1;
    logic [0:63] rdata0, rdata1, wdata0, wdata1;

    int checks = 0;
    int errors = 0;

    logic [63:0] mdl [32];
    logic [63:0] exp0, exp1;

    gpr_file dut (
        .clk(clk), .reset(reset),
        .raddr0_en(raddr0_en), .raddr0(raddr0), .rdata0(rdata0),
        .raddr1_en(raddr1_en), .raddr1(raddr1), .rdata1(rdata1),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model by the architectural rules, then compare both read ports.
    task automatic step(input logic rst,
                        input logic re0, input logic [4:0] ra0,
                        input logic re1, input logic [4:0] ra1,
                        input logic we0, input logic [4:0] wa0, input logic [63:0] wd0,
                        input logic we1, input logic [4:0] wa1, input logic [63:0] wd1,
                        input string tag);
        logic [63:0] nxt [32];
        reset = rst;
        raddr0_en = re0; raddr0 = ra0; raddr1_en = re1; raddr1 = ra1;
        wen0 = we0; waddr0 = wa0; wdata0 = wd0;
        wen1 = we1; waddr1 = wa1; wdata1 = wd1;
        if (rst) begin
            foreach (mdl[i]) mdl[i] = 64'd0;
            exp0 = 64'd0;
            exp1 = 64'd0;
        end else begin
            nxt = mdl;
            if (we0) nxt[wa0] = wd0;
            if (we1) nxt[wa1] = wd1;
`ifdef GPR_BYPASS_EN
            if (re0) exp0 = nxt[ra0];
            if (re1) exp1 = nxt[ra1];
`else
            if (re0) exp0 = mdl[ra0];
            if (re1) exp1 = mdl[ra1];
`endif
            mdl = nxt;
        end
        @(posedge clk);
        #1;
        check({tag, "_rdata0"}, rdata0, exp0);
        check({tag, "_rdata1"}, rdata1, exp1);
    endtask

    task automatic wr0(input logic [4:0] a, input logic [63:0] d, input string tag);
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, a, d, 1'b0, 5'd0, 64'd0, tag);
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input string tag);
        step(1'b0, 1'b1, a0, 1'b1, a1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, tag);
    endtask

    initial begin
        logic [4:0] a [4];
        logic       rst;
        logic [63:0] same_cycle_exp;

        reset = 1'b1;
        raddr0_en = 1'b0; raddr1_en = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
        raddr0 = '0; raddr1 = '0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;

        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "reset0");
        check("reset_rdata0", rdata0, 64'd0);

        // Reset clears storage
        wr0(5'd5, 64'hDEADBEEF_00000001, "w_r5");
        rd(5'd5, 5'd5, "pre_reset_rd_r5");
        check("pre_reset_r5", rdata0, 64'hDEADBEEF_00000001);
        step(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 64'h1234, 1'b1, 5'd5, 64'h5678, "reset1");
        rd(5'd5, 5'd5, "post_reset_rd_r5");
        check("reset_r5_p0", rdata0, 64'd0);
        check("reset_r5_p1", rdata1, 64'd0);

        // Read and hold
        wr0(5'd3, 64'h41, "w_r3");
        step(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "rd1_r3");
        check("read_r3_p1", rdata1, 64'h41);
        wr0(5'd3, 64'd7, "w_r3_7");
        check("hold_p1", rdata1, 64'h41);
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, "idle");
        check("hold_p1_idle", rdata1, 64'h41);

        // Dual write to different addresses
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 64'h10, 1'b1, 5'd9, 64'h20, "dual_w");
        rd(5'd4, 5'd9, "dual_rd");
        check("dual_r4", rdata0, 64'h10);
        check("dual_r9", rdata1, 64'h20);

        // Collision: port 1 wins
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 64'h1111, 1'b1, 5'd7, 64'h2222, "coll_w");
        rd(5'd7, 5'd7, "coll_rd");
        check("coll_r7_p0", rdata0, 64'h2222);
        check("coll_r7_p1", rdata1, 64'h2222);

        // Same-cycle read/write
`ifdef GPR_BYPASS_EN
        same_cycle_exp = 64'd9;
`else
        same_cycle_exp = 64'd5;
`endif
        wr0(5'd2, 64'd5, "w_r2_5");
        step(1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd2, 64'd9, 1'b0, 5'd0, 64'd0, "rw_r2");
        check("same_cycle_r2", rdata0, same_cycle_exp);
        rd(5'd2, 5'd2, "rd_r2_next");
        check("next_r2", rdata0, 64'd9);

        // r0 is ordinary storage
        wr0(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, "w_r0");
        rd(5'd0, 5'd0, "rd_r0");
        check("r0_ones", rdata1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Randomized traffic, addresses biased to a small set to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 4; k++) begin
                a[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            end
            rst = ($urandom_range(0, 99) == 0);
            step(rst, 1'($urandom), a[0], 1'($urandom), a[1],
                 1'($urandom), a[2], {$urandom, $urandom},
                 1'($urandom), a[3], {$urandom, $urandom}, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
